exibidor_sequencia: RTL and testbench

//   Upstream stage of decodificador_rgb in the memory game. On a start pulse it

---
 rtl/exibidor_sequencia_pkg.sv | 18 +
 rtl/contador_m.sv | 29 ++
 rtl/exibidor_sequencia.sv | 93 +++++++++
 tb/tb_exibidor_sequencia.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exibidor_sequencia_pkg.sv
// Shared definitions for the sequence player: FSM states and the one-hot play codes
// understood by decodificador_rgb.
package exibidor_sequencia_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [3:0] JOGADA_0 = 4'b0001;
  localparam logic [3:0] JOGADA_1 = 4'b0010;
  localparam logic [3:0] JOGADA_2 = 4'b0100;
  localparam logic [3:0] JOGADA_3 = 4'b1000;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with async and sync clears; fim flags the terminal count M-1.
// Zero-latency flag, no backpressure (counts whenever conta=1).
module contador_m #(
  parameter int M = 16,
  localparam int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [W-1:0] Q,
  output logic         fim
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      Q <= '0;
    end else if (zera_s) begin
      Q <= '0;
    end else if (conta) begin
      Q <= (Q == ULTIMO) ? '0 : Q + 1'b1;
    end
  end

  assign fim = (Q == ULTIMO);

endmodule

// File: rtl/exibidor_sequencia.sv
// Replays the stored play sequence (addresses 0..limite) to the RGB decoder, each play
// lit for T_ON cycles then dark for T_OFF cycles; start sampled only when idle.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        mem_dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        dados,
  output logic              en,
  output logic              ocupado,
  output logic              pronto
);

  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] ON_ULTIMO  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_ULTIMO = CW'(T_OFF - 1);

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] limite_reg;
  logic [CW-1:0]     contagem;
  logic              fim_max, fim_on, fim_off, fim_fase;
  logic              temporizando, zera_s;

  // One shared timer sized for the longer phase; the longer phase reuses its wrap flag.
  assign fim_on  = (T_ON  == TMAX) ? fim_max : (contagem == ON_ULTIMO);
  assign fim_off = (T_OFF == TMAX) ? fim_max : (contagem == OFF_ULTIMO);

  assign temporizando = (estado == ACESO) || (estado == APAGADO);
  assign fim_fase     = ((estado == ACESO) && fim_on) || ((estado == APAGADO) && fim_off);
  assign zera_s       = !temporizando || fim_fase;

  contador_m #(.M(TMAX)) u_temporizador (
    .clock   (clock),
    .zera_as (~reset),
    .zera_s  (zera_s),
    .conta   (temporizando),
    .Q       (contagem),
    .fim     (fim_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: if (iniciar) proximo = CARREGA;
      CARREGA: proximo = ACESO;
      ACESO:   if (fim_on) proximo = APAGADO;
      APAGADO: if (fim_off) proximo = (endereco == limite_reg) ? FIM : CARREGA;
      FIM:     proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco   <= '0;
      dados      <= '0;
      limite_reg <= '0;
    end else begin
      case (estado)
        INICIAL: if (iniciar) begin
          endereco   <= '0;
          limite_reg <= limite;
        end
        CARREGA: dados <= mem_dado;
        APAGADO: if (fim_off && (endereco != limite_reg)) endereco <= endereco + 1'b1;
        FIM:     endereco <= '0;
        default: ;
      endcase
    end
  end

  assign en      = (estado == ACESO);
  assign ocupado = (estado != INICIAL);
  assign pronto  = (estado == FIM);

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with T_ON=4, T_OFF=2 and an async-read memory array.
module tb_exibidor_sequencia;

  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int ADDR_W = 4;
  localparam int PER    = 1 + T_ON + T_OFF;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [ADDR_W-1:0] limite;
  logic [3:0]        mem_dado;
  logic [ADDR_W-1:0] endereco;
  logic [3:0]        dados;
  logic              en;
  logic              ocupado;
  logic              pronto;

  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;

  assign mem_dado = mem[endereco];

  always #5 clock = ~clock;

  exibidor_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .limite   (limite),
    .mem_dado (mem_dado),
    .endereco (endereco),
    .dados    (dados),
    .en       (en),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    iniciar = 1'b1;
    limite  = '0;
    tick();
    tick();
    checks++;
    if ({endereco, dados, en, ocupado, pronto} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got end=%h dados=%b en=%b oc=%b pr=%b required all 0",
               endereco, dados, en, ocupado, pronto);
    end
    iniciar = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ocupado !== 1'b0 || en !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d got oc=%b en=%b required 0 0", i, ocupado, en);
      end
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL start_from_idle got oc=%b required 1", ocupado);
    end
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // Walks limite+1 plays; bump_a/bump_b are cycle indices where iniciar is re-asserted.
  task automatic test_walk(input int lim, input int bump_a, input int bump_b);
    int total, p, ph;
    logic exp_en, exp_pr, exp_oc;
    logic [3:0] exp_addr, exp_dados;
    total   = (lim + 1) * PER;
    limite  = lim[ADDR_W-1:0];
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    limite  = ~limite;
    for (int j = 1; j <= total + 2; j++) begin
      p  = (j - 1) / PER;
      ph = (j - 1) % PER;
      exp_oc   = (j <= total + 1);
      exp_pr   = (j == total + 1);
      exp_en   = (j <= total) && (ph >= 1) && (ph <= T_ON);
      exp_addr = (j <= total) ? p[3:0] : ((j == total + 1) ? lim[3:0] : 4'd0);
      exp_dados = mem[p[3:0]];
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL walk%0d_en j=%0d got %b required %b", lim, j, en, exp_en);
      end
      checks++;
      if (pronto !== exp_pr) begin
        errors++;
        $display("FAIL walk%0d_pronto j=%0d got %b required %b", lim, j, pronto, exp_pr);
      end
      checks++;
      if (ocupado !== exp_oc) begin
        errors++;
        $display("FAIL walk%0d_ocupado j=%0d got %b required %b", lim, j, ocupado, exp_oc);
      end
      checks++;
      if (endereco !== exp_addr) begin
        errors++;
        $display("FAIL walk%0d_endereco j=%0d got %0d required %0d", lim, j, endereco, exp_addr);
      end
      if (exp_en) begin
        checks++;
        if (dados !== exp_dados) begin
          errors++;
          $display("FAIL walk%0d_dados j=%0d got %b required %b", lim, j, dados, exp_dados);
        end
      end
      iniciar = (j == bump_a || j == bump_b);
      tick();
    end
    iniciar = 1'b0;
  endtask

  task automatic test_reset_mid();
    limite  = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (16) tick();
    checks++;
    if (en !== 1'b1 || endereco !== 4'd2) begin
      errors++;
      $display("FAIL mid_precondition got en=%b end=%0d required 1 2", en, endereco);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || endereco !== 4'd0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async got en=%b end=%0d oc=%b pr=%b required 0 0 0 0",
               en, endereco, ocupado, pronto);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (pronto !== 1'b0 || ocupado !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_resume cycle %0d got pr=%b oc=%b required 0 0", i, pronto, ocupado);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    iniciar = 1'b0;
    limite  = '0;
    mem[0]  = 4'b0001; mem[1]  = 4'b0010; mem[2]  = 4'b0100; mem[3]  = 4'b1000;
    mem[4]  = 4'b0000; mem[5]  = 4'b0011; mem[6]  = 4'b0001; mem[7]  = 4'b0010;
    mem[8]  = 4'b1111; mem[9]  = 4'b0100; mem[10] = 4'b1000; mem[11] = 4'b0110;
    mem[12] = 4'b0001; mem[13] = 4'b0010; mem[14] = 4'b0100; mem[15] = 4'b1000;
    #1;
    test_reset();
    test_walk(0, 0, 0);
    test_walk(3, 0, 0);
    test_walk(3, 3, 4 * PER + 1);
    test_reset_mid();
    test_walk(1, 0, 0);
    test_walk(15, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
